// File: rtl/modbus_rtu_pkg.sv
// Shared definitions for the Modbus RTU frame receiver.
//
// Contents:
//   state_e             receiver FSM states
//   FRAME_LEN_W         width of the frame length counter (0..256)
//   CRC_INIT/CRC_POLY   CRC-16/MODBUS constants (reflected form)
//   crc16_modbus_byte() folds one byte into a running CRC-16/MODBUS
//   t15_clks()/t35_clks() convert the t1.5 / t3.5 silence times to clock cycles
package modbus_rtu_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RECV,
        GAP,
        HOLD,
        DISCARD,
        DISCARD_HOLD
    } state_e;

    localparam int          FRAME_LEN_W = 9;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_POLY    = 16'hA001;

    // LSB-first CRC update, one byte at a time.
    function automatic logic [15:0] crc16_modbus_byte(input logic [15:0] crc_in,
                                                      input logic [7:0]  data_in);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // A character is 11 bits. Above 19200 baud the standard fixes the
    // silence times at 750us / 1750us instead of scaling with the baud rate.
    function automatic int t15_clks(input int clk_freq, input int baud_rate);
        longint v;
        if (baud_rate <= 19200) begin
            v = (longint'(clk_freq) * 33) / (longint'(baud_rate) * 2);
        end else begin
            v = (longint'(clk_freq) * 750) / 1000000;
        end
        return int'(v);
    endfunction

    function automatic int t35_clks(input int clk_freq, input int baud_rate);
        longint v;
        if (baud_rate <= 19200) begin
            v = (longint'(clk_freq) * 77) / (longint'(baud_rate) * 2);
        end else begin
            v = (longint'(clk_freq) * 1750) / 1000000;
        end
        return int'(v);
    endfunction

endpackage

// File: rtl/modbus_rtu_frame_rx_ctrl_silence_timer.sv
// Line silence timer for Modbus RTU framing.
//
// Counts clock cycles since the line was last busy and flags when the
// t1.5 and t3.5 silence thresholds have been reached.
//
// Ports:
//   clk_in    system clock
//   rst_n_in  asynchronous reset, active low
//   clear     line activity this cycle (character on line or byte done)
//   t15_hit   level: silence >= T15 cycles
//   t35_hit   level: silence has saturated at T35 cycles
module modbus_silence_timer #(
    parameter int T15 = 165,
    parameter int T35 = 385
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clear,
    output logic t15_hit,
    output logic t35_hit
);

    localparam int CNT_W = $clog2(T35 + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating counter so the t3.5 flag stays up for as long as the line is quiet.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(T35)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign t15_hit = (cnt_q >= CNT_W'(T15));
    assign t35_hit = (cnt_q == CNT_W'(T35));

endmodule

// File: rtl/modbus_rtu_frame_rx_ctrl.sv
// Modbus RTU frame receive controller.
//
// Frames the UART byte stream into Modbus RTU frames using t1.5 / t3.5
// silence timing, writes every frame byte into an external buffer, filters
// on slave address and hands finished frames to the request decoder with a
// valid/ack handshake.
//
// Optional feature: define MODBUS_CRC_CHECK_EN to run a CRC-16/MODBUS over
// every written byte and report the residue check on frame_crc_ok. Without
// it frame_crc_ok reads 1 for every presented frame.
//
// Ports:
//   clk_in, rst_n_in             clock, asynchronous active-low reset
//   rx_data, rx_done, rx_state   byte receiver interface
//   buf_wr_en/addr/data          frame buffer write port (1 cycle after rx_done)
//   frame_valid, frame_ack       frame handoff handshake
//   frame_len                    byte count including CRC
//   frame_bcast, frame_crc_ok    frame flags, stable while frame_valid
//   err_pulse                    one-cycle pulse when a frame is dropped
import modbus_rtu_pkg::*;

module modbus_rtu_frame_rx_ctrl #(
    parameter int         CLK_FREQ  = 50000000,
    parameter int         BAUD_RATE = 9600,
    parameter logic [7:0] DEV_ADDR  = 8'h01,
    parameter int         MAX_LEN   = 256
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [7:0]             rx_data,
    input  logic                   rx_done,
    input  logic                   rx_state,
    output logic                   buf_wr_en,
    output logic [7:0]             buf_wr_addr,
    output logic [7:0]             buf_wr_data,
    output logic                   frame_valid,
    output logic [FRAME_LEN_W-1:0] frame_len,
    output logic                   frame_bcast,
    output logic                   frame_crc_ok,
    input  logic                   frame_ack,
    output logic                   err_pulse
);

    localparam int                   T15     = t15_clks(CLK_FREQ, BAUD_RATE);
    localparam int                   T35     = t35_clks(CLK_FREQ, BAUD_RATE);
    localparam logic [FRAME_LEN_W-1:0] LEN_MAX = FRAME_LEN_W'(MAX_LEN);

    logic t15_hit;
    logic t35_hit;

    state_e                 state_q,        state_d;
    logic [FRAME_LEN_W-1:0] len_q,          len_d;
    logic [7:0]             addr_byte_q,    addr_byte_d;
    logic                   buf_wr_en_q,    buf_wr_en_d;
    logic [7:0]             buf_wr_addr_q,  buf_wr_addr_d;
    logic [7:0]             buf_wr_data_q,  buf_wr_data_d;
    logic                   frame_valid_q,  frame_valid_d;
    logic [FRAME_LEN_W-1:0] frame_len_q,    frame_len_d;
    logic                   frame_bcast_q,  frame_bcast_d;
    logic                   frame_crc_ok_q, frame_crc_ok_d;
    logic                   err_pulse_q,    err_pulse_d;

    logic start_frame;
    logic append_byte;
    logic crc_good;

`ifdef MODBUS_CRC_CHECK_EN
    logic [15:0] crc_q, crc_d;
    assign crc_good = (crc_q == 16'h0000);
`else
    assign crc_good = 1'b1;
`endif

    modbus_silence_timer #(
        .T15 (T15),
        .T35 (T35)
    ) u_silence_timer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clear    (rx_state | rx_done),
        .t15_hit  (t15_hit),
        .t35_hit  (t35_hit)
    );

    // Next-state and output logic. The case decides what to do with an
    // arriving byte; the shared write path below the case performs it.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        addr_byte_d    = addr_byte_q;
        buf_wr_en_d    = 1'b0;
        buf_wr_addr_d  = buf_wr_addr_q;
        buf_wr_data_d  = buf_wr_data_q;
        frame_valid_d  = frame_valid_q;
        frame_len_d    = frame_len_q;
        frame_bcast_d  = frame_bcast_q;
        frame_crc_ok_d = frame_crc_ok_q;
        err_pulse_d    = 1'b0;
        start_frame    = 1'b0;
        append_byte    = 1'b0;
`ifdef MODBUS_CRC_CHECK_EN
        crc_d          = crc_q;
`endif

        case (state_q)
            INIT: begin
                // Bytes here are ignored; they also restart the silence wait.
                if (t35_hit && !rx_done) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (rx_done) begin
                    start_frame = 1'b1;
                end
            end
            RECV: begin
                if (rx_done) begin
                    append_byte = 1'b1;
                end else if (t15_hit) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                // A byte landing exactly on t3.5 expiry still belongs to the frame.
                if (rx_done && t35_hit) begin
                    append_byte = 1'b1;
                end else if (rx_done) begin
                    err_pulse_d = 1'b1;
                    state_d     = DISCARD;
                end else if (t35_hit) begin
                    if (len_q < FRAME_LEN_W'(4)) begin
                        err_pulse_d = 1'b1;
                        state_d     = IDLE;
                    end else if ((addr_byte_q != DEV_ADDR) && (addr_byte_q != 8'h00)) begin
                        state_d = IDLE;
                    end else begin
                        frame_valid_d  = 1'b1;
                        frame_len_d    = len_q;
                        frame_bcast_d  = (addr_byte_q == 8'h00);
                        frame_crc_ok_d = crc_good;
                        state_d        = HOLD;
                    end
                end
            end
            HOLD: begin
                // The buffer is owned by the consumer, so a new byte kills the new frame.
                if (rx_done) begin
                    err_pulse_d = 1'b1;
                    if (frame_ack) begin
                        frame_valid_d = 1'b0;
                        state_d       = DISCARD;
                    end else begin
                        state_d = DISCARD_HOLD;
                    end
                end else if (frame_ack) begin
                    frame_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            DISCARD_HOLD: begin
                if (frame_ack) begin
                    frame_valid_d = 1'b0;
                    state_d       = DISCARD;
                end
            end
            DISCARD: begin
                if (t35_hit && !rx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        if (start_frame) begin
            buf_wr_en_d   = 1'b1;
            buf_wr_addr_d = 8'h00;
            buf_wr_data_d = rx_data;
            len_d         = FRAME_LEN_W'(1);
            addr_byte_d   = rx_data;
            state_d       = RECV;
`ifdef MODBUS_CRC_CHECK_EN
            crc_d         = crc16_modbus_byte(CRC_INIT, rx_data);
`endif
        end

        if (append_byte) begin
            if (len_q == LEN_MAX) begin
                err_pulse_d = 1'b1;
                state_d     = DISCARD;
            end else begin
                buf_wr_en_d   = 1'b1;
                buf_wr_addr_d = len_q[7:0];
                buf_wr_data_d = rx_data;
                len_d         = len_q + 1'b1;
                state_d       = RECV;
`ifdef MODBUS_CRC_CHECK_EN
                crc_d         = crc16_modbus_byte(crc_q, rx_data);
`endif
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= INIT;
            len_q          <= '0;
            addr_byte_q    <= '0;
            buf_wr_en_q    <= 1'b0;
            buf_wr_addr_q  <= '0;
            buf_wr_data_q  <= '0;
            frame_valid_q  <= 1'b0;
            frame_len_q    <= '0;
            frame_bcast_q  <= 1'b0;
            frame_crc_ok_q <= 1'b0;
            err_pulse_q    <= 1'b0;
`ifdef MODBUS_CRC_CHECK_EN
            crc_q          <= CRC_INIT;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            addr_byte_q    <= addr_byte_d;
            buf_wr_en_q    <= buf_wr_en_d;
            buf_wr_addr_q  <= buf_wr_addr_d;
            buf_wr_data_q  <= buf_wr_data_d;
            frame_valid_q  <= frame_valid_d;
            frame_len_q    <= frame_len_d;
            frame_bcast_q  <= frame_bcast_d;
            frame_crc_ok_q <= frame_crc_ok_d;
            err_pulse_q    <= err_pulse_d;
`ifdef MODBUS_CRC_CHECK_EN
            crc_q          <= crc_d;
`endif
        end
    end

    assign buf_wr_en    = buf_wr_en_q;
    assign buf_wr_addr  = buf_wr_addr_q;
    assign buf_wr_data  = buf_wr_data_q;
    assign frame_valid  = frame_valid_q;
    assign frame_len    = frame_len_q;
    assign frame_bcast  = frame_bcast_q;
    assign frame_crc_ok = frame_crc_ok_q;
    assign err_pulse    = err_pulse_q;

endmodule

// File: tb/tb_modbus_rtu_frame_rx_ctrl.sv
// Self-checking bench for modbus_rtu_frame_rx_ctrl.
//
// Drives frames byte by byte, predicts the outcome of each frame from the
// framing rules (gap, length, address, CRC) and compares the observed
// buffer writes, error pulses and handoff outputs against the prediction.
// Uses a slow clock so that t1.5 / t3.5 are a few hundred cycles.
module tb_modbus_rtu_frame_rx_ctrl;

    localparam int         CLK_FREQ  = 96000;
    localparam int         BAUD_RATE = 9600;
    localparam logic [7:0] DEV_ADDR  = 8'h01;
    localparam int         MAX_LEN   = 256;

    localparam int CHAR_CLKS  = CLK_FREQ * 11 / BAUD_RATE;
    localparam int T15        = CHAR_CLKS * 3 / 2;
    localparam int T35        = CHAR_CLKS * 7 / 2;
    localparam int GAP_BAD    = 2 * CHAR_CLKS;
    localparam int END_WAIT   = T35 + 30;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_state;
    logic       buf_wr_en;
    logic [7:0] buf_wr_addr;
    logic [7:0] buf_wr_data;
    logic       frame_valid;
    logic [8:0] frame_len;
    logic       frame_bcast;
    logic       frame_crc_ok;
    logic       frame_ack;
    logic       err_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];
    int         err_seen;
    logic [7:0] tx_bytes[$];

    modbus_rtu_frame_rx_ctrl #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .DEV_ADDR  (DEV_ADDR),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .rx_state     (rx_state),
        .buf_wr_en    (buf_wr_en),
        .buf_wr_addr  (buf_wr_addr),
        .buf_wr_data  (buf_wr_data),
        .frame_valid  (frame_valid),
        .frame_len    (frame_len),
        .frame_bcast  (frame_bcast),
        .frame_crc_ok (frame_crc_ok),
        .frame_ack    (frame_ack),
        .err_pulse    (err_pulse)
    );

    always #5 clk_in = ~clk_in;

    // Passive monitor: logs buffer writes and counts error-pulse cycles.
    always @(negedge clk_in) begin
        if (buf_wr_en) begin
            wr_addr_log.push_back(buf_wr_addr);
            wr_data_log.push_back(buf_wr_data);
        end
        if (err_pulse) begin
            err_seen++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_monitor();
        wr_addr_log.delete();
        wr_data_log.delete();
        err_seen = 0;
    endtask

    // One character: quiet gap, character on the line, then the done pulse.
    task automatic send_byte(input logic [7:0] b, input int gap_before);
        repeat (gap_before) step();
        rx_state = 1'b1;
        repeat (8) step();
        rx_state = 1'b0;
        rx_done  = 1'b1;
        rx_data  = b;
        step();
        rx_done  = 1'b0;
    endtask

    // Bit-serial CRC-16/MODBUS over the first count bytes of tx_bytes.
    function automatic logic [15:0] model_crc(input int count);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        for (int i = 0; i < count; i++) begin
            for (int k = 0; k < 8; k++) begin
                fb = r[0] ^ tx_bytes[i][k];
                r  = r >> 1;
                if (fb) r = r ^ 16'hA001;
            end
        end
        return r;
    endfunction

    function automatic void append_crc();
        logic [15:0] c;
        c = model_crc(tx_bytes.size());
        tx_bytes.push_back(c[7:0]);
        tx_bytes.push_back(c[15:8]);
    endfunction

    // Sends tx_bytes (optionally with one long gap before byte gap_idx),
    // predicts the frame outcome and checks it; acks a presented frame if asked.
    task automatic applyStimulus(input string tag, input int gap_idx, input int gap_len,
                                 input bit do_ack);
        int   n;
        int   exp_wr;
        int   exp_err;
        bit   exp_valid;
        bit   exp_crc_ok;
        int   bad;
        n = tx_bytes.size();
        clear_monitor();
        for (int i = 0; i < n; i++) begin
            send_byte(tx_bytes[i], (i == gap_idx) ? gap_len : int'($urandom_range(0, 20)));
        end
        repeat (END_WAIT) step();

        exp_valid  = 1'b0;
        exp_crc_ok = 1'b1;
        if (gap_idx >= 1 && gap_idx < n && gap_len >= T15 && gap_len < T35) begin
            exp_wr  = gap_idx;
            exp_err = 1;
        end else if (n > MAX_LEN) begin
            exp_wr  = MAX_LEN;
            exp_err = 1;
        end else begin
            exp_wr = n;
            if (n < 4) begin
                exp_err = 1;
            end else begin
                exp_err   = 0;
                exp_valid = (tx_bytes[0] == DEV_ADDR) || (tx_bytes[0] == 8'h00);
`ifdef MODBUS_CRC_CHECK_EN
                exp_crc_ok = (model_crc(n - 2) == {tx_bytes[n-1], tx_bytes[n-2]});
`endif
            end
        end

        bad = 0;
        for (int i = 0; i < wr_addr_log.size(); i++) begin
            if (wr_addr_log[i] != 8'(i) || i >= n || wr_data_log[i] != tx_bytes[i]) bad++;
        end
        checkOutput({tag, "_wr_count"}, 32'(wr_addr_log.size()), 32'(exp_wr));
        checkOutput({tag, "_wr_content"}, 32'(bad), 32'd0);
        checkOutput({tag, "_err"}, 32'(err_seen), 32'(exp_err));
        checkOutput({tag, "_valid"}, 32'(frame_valid), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput({tag, "_len"}, 32'(frame_len), 32'(n));
            checkOutput({tag, "_bcast"}, 32'(frame_bcast), 32'(tx_bytes[0] == 8'h00));
            checkOutput({tag, "_crc_ok"}, 32'(frame_crc_ok), 32'(exp_crc_ok));
            if (do_ack) begin
                frame_ack = 1'b1;
                step();
                frame_ack = 1'b0;
                checkOutput({tag, "_valid_drop"}, 32'(frame_valid), 32'd0);
            end
        end
    endtask

    function automatic void load_req_frame(input logic [7:0] last);
        tx_bytes = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, last};
    endfunction

    initial begin
        int n;
        rst_n_in  = 1'b0;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        rx_state  = 1'b0;
        frame_ack = 1'b0;
        err_seen  = 0;
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("reset_outputs",
                    32'({buf_wr_en, buf_wr_addr, buf_wr_data, frame_valid, frame_len,
                         frame_bcast, frame_crc_ok, err_pulse}), 32'd0);
        rst_n_in = 1'b1;
        repeat (END_WAIT) step();

        $display("[TB] directed frames");
        load_req_frame(8'h0A);
        applyStimulus("req_good", -1, 0, 1'b1);
        load_req_frame(8'h0B);
        applyStimulus("req_badcrc", -1, 0, 1'b1);
        tx_bytes = '{8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        append_crc();
        applyStimulus("other_addr", -1, 0, 1'b1);
        tx_bytes = '{8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03};
        append_crc();
        applyStimulus("bcast", -1, 0, 1'b1);
        load_req_frame(8'h0A);
        applyStimulus("gap_err", 3, GAP_BAD, 1'b1);
        load_req_frame(8'h0A);
        applyStimulus("after_gap", -1, 0, 1'b1);

        tx_bytes.delete();
        tx_bytes.push_back(DEV_ADDR);
        for (int i = 1; i < MAX_LEN + 1; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
        applyStimulus("overflow", -1, 0, 1'b1);
        tx_bytes = '{8'h01, 8'h03};
        applyStimulus("short", -1, 0, 1'b1);

        $display("[TB] byte while frame held");
        load_req_frame(8'h0A);
        applyStimulus("hold_a", -1, 0, 1'b0);
        clear_monitor();
        send_byte(8'h01, 5);
        send_byte(8'h03, 5);
        send_byte(8'h00, 5);
        repeat (END_WAIT) step();
        checkOutput("hold_err", 32'(err_seen), 32'd1);
        checkOutput("hold_no_write", 32'(wr_addr_log.size()), 32'd0);
        checkOutput("hold_valid_kept", 32'(frame_valid), 32'd1);
        checkOutput("hold_len_kept", 32'(frame_len), 32'd8);
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        checkOutput("hold_valid_drop", 32'(frame_valid), 32'd0);
        repeat (5) step();
        load_req_frame(8'h0A);
        applyStimulus("after_hold", -1, 0, 1'b1);

        $display("[TB] random frames");
        for (int f = 0; f < 16; f++) begin
            int r;
            n = (($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3))
                                              : int'($urandom_range(4, 14)));
            tx_bytes.delete();
            r = int'($urandom_range(0, 3));
            tx_bytes.push_back((r == 0) ? 8'h01 : (r == 1) ? 8'h00 : (r == 2) ? 8'h02
                                        : 8'($urandom_range(0, 255)));
            if (n >= 4) begin
                for (int i = 1; i < n - 2; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
                if ($urandom_range(0, 3) != 0) begin
                    append_crc();
                end else begin
                    tx_bytes.push_back(8'($urandom_range(0, 255)));
                    tx_bytes.push_back(8'($urandom_range(0, 255)));
                end
            end else begin
                for (int i = 1; i < n; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
            end
            if (n >= 2 && $urandom_range(0, 4) == 0) begin
                applyStimulus($sformatf("rand%0d", f), int'($urandom_range(1, n - 1)), GAP_BAD, 1'b1);
            end else begin
                applyStimulus($sformatf("rand%0d", f), -1, 0, 1'b1);
            end
        end

        $display("[TB] reset mid-frame");
        clear_monitor();
        send_byte(8'h01, 3);
        send_byte(8'h03, 3);
        send_byte(8'h05, 3);
        rx_state = 1'b1;
        repeat (3) step();
        rst_n_in = 1'b0;
        #2;
        checkOutput("midreset_outputs",
                    32'({buf_wr_en, buf_wr_addr, buf_wr_data, frame_valid, frame_len,
                         frame_bcast, frame_crc_ok, err_pulse}), 32'd0);
        rx_state = 1'b0;
        step();
        rst_n_in = 1'b1;
        clear_monitor();
        load_req_frame(8'h0A);
        for (int i = 0; i < 8; i++) send_byte(tx_bytes[i], 4);
        repeat (END_WAIT) step();
        checkOutput("init_ignore_wr", 32'(wr_addr_log.size()), 32'd0);
        checkOutput("init_ignore_err", 32'(err_seen), 32'd0);
        checkOutput("init_ignore_valid", 32'(frame_valid), 32'd0);
        load_req_frame(8'h0A);
        applyStimulus("after_reset", -1, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
